// File: rtl/lc3_regfile_sb.sv
// LC-3 register file with a folded DR write-enable decoder, two combinational
// read ports with optional same-cycle write forwarding, and a per-register busy
// scoreboard that gates instruction issue against pending writebacks.
module lc3_regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                LD_REG,
  input  logic [ADDR_W-1:0]   DR,
  input  logic [DATA_W-1:0]   D_in,
  input  logic [ADDR_W-1:0]   SR1,
  input  logic [ADDR_W-1:0]   SR2,
  output logic [DATA_W-1:0]   SR1_OUT,
  output logic [DATA_W-1:0]   SR2_OUT,
  input  logic                ISSUE_VALID,
  input  logic [ADDR_W-1:0]   ISSUE_DR,
  output logic                ISSUE_STALL,
  output logic                SR1_BUSY,
  output logic                SR2_BUSY,
  output logic [NUM_REGS-1:0] WE_VEC,
  output logic [NUM_REGS-1:0] BUSY_VEC
);

  localparam logic BYP_EN = (BYPASS != 0);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                issue_accept;
  logic                fwd1;
  logic                fwd2;

  // One-hot write-enable decode of DR, all-zero when no writeback
  always_comb begin
    WE_VEC = '0;
    if (LD_REG) begin
      WE_VEC[DR] = 1'b1;
    end
  end

  // Register storage: reset clears everything and discards a coincident write
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (WE_VEC[i]) begin
          regs[i] <= D_in;
        end
      end
    end
  end

  // Read ports with optional forwarding of the in-flight writeback
  always_comb begin
    fwd1    = BYP_EN && LD_REG && (DR == SR1);
    fwd2    = BYP_EN && LD_REG && (DR == SR2);
    SR1_OUT = fwd1 ? D_in : regs[SR1];
    SR2_OUT = fwd2 ? D_in : regs[SR2];
  end

  // Issue gating and operand busy flags; a same-cycle writeback hides busy
  always_comb begin
    ISSUE_STALL  = ISSUE_VALID && busy[ISSUE_DR] && !(LD_REG && (DR == ISSUE_DR));
    issue_accept = ISSUE_VALID && !ISSUE_STALL;
    SR1_BUSY     = busy[SR1] && !fwd1;
    SR2_BUSY     = busy[SR2] && !fwd2;
    BUSY_VEC     = busy;
  end

  // Scoreboard next state: writeback clears first, accepted issue sets last
  always_comb begin
    busy_next = busy;
    if (LD_REG) begin
      busy_next[DR] = 1'b0;
    end
    if (issue_accept) begin
      busy_next[ISSUE_DR] = 1'b1;
    end
  end

  // Scoreboard state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Bench for lc3_regfile_sb: a forwarding and a non-forwarding instance share
// stimulus; directed scenarios followed by random traffic against an array model.
module tb_lc3_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        ld;
  logic [2:0]  dr;
  logic [15:0] din;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        iv;
  logic [2:0]  idr;

  logic [15:0] sr1_out_b, sr2_out_b, sr1_out_n, sr2_out_n;
  logic        stall_b, stall_n, sr1_busy_b, sr2_busy_b, sr1_busy_n, sr2_busy_n;
  logic [7:0]  we_b, we_n, busyv_b, busyv_n;

  int checks = 0;
  int failures = 0;

  logic [15:0] mregs [8];
  logic [7:0]  mbusy;

  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1)) u_byp (
    .Clk(clk), .Reset_n(rst_n), .LD_REG(ld), .DR(dr), .D_in(din),
    .SR1(sr1), .SR2(sr2), .SR1_OUT(sr1_out_b), .SR2_OUT(sr2_out_b),
    .ISSUE_VALID(iv), .ISSUE_DR(idr), .ISSUE_STALL(stall_b),
    .SR1_BUSY(sr1_busy_b), .SR2_BUSY(sr2_busy_b),
    .WE_VEC(we_b), .BUSY_VEC(busyv_b)
  );

  lc3_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .BYPASS(0)) u_nob (
    .Clk(clk), .Reset_n(rst_n), .LD_REG(ld), .DR(dr), .D_in(din),
    .SR1(sr1), .SR2(sr2), .SR1_OUT(sr1_out_n), .SR2_OUT(sr2_out_n),
    .ISSUE_VALID(iv), .ISSUE_DR(idr), .ISSUE_STALL(stall_n),
    .SR1_BUSY(sr1_busy_n), .SR2_BUSY(sr2_busy_n),
    .WE_VEC(we_n), .BUSY_VEC(busyv_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's inputs mid-period and let combinational outputs settle
  task automatic drive(input bit r, input bit l, input int d, input int data,
                       input int s1, input int s2, input bit v, input int id);
    @(negedge clk);
    rst_n = r; ld = l; dr = 3'(d); din = 16'(data);
    sr1 = 3'(s1); sr2 = 3'(s2); iv = v; idr = 3'(id);
    #1;
  endtask

  // Compare every output of both instances with the rules applied to the model
  task automatic model_check();
    logic        hit1, hit2, stall;
    logic [7:0]  we;
    hit1  = ld && (dr == sr1);
    hit2  = ld && (dr == sr2);
    stall = iv && mbusy[idr] && !(ld && (dr == idr));
    we    = ld ? (8'd1 << dr) : 8'd0;
    check("m_sr1_byp",   32'(sr1_out_b),  32'(hit1 ? din : mregs[sr1]));
    check("m_sr2_byp",   32'(sr2_out_b),  32'(hit2 ? din : mregs[sr2]));
    check("m_sr1_nob",   32'(sr1_out_n),  32'(mregs[sr1]));
    check("m_sr2_nob",   32'(sr2_out_n),  32'(mregs[sr2]));
    check("m_stall",     32'(stall_b),    32'(stall));
    check("m_stall_nob", 32'(stall_n),    32'(stall));
    check("m_b1_byp",    32'(sr1_busy_b), 32'(mbusy[sr1] && !hit1));
    check("m_b2_byp",    32'(sr2_busy_b), 32'(mbusy[sr2] && !hit2));
    check("m_b1_nob",    32'(sr1_busy_n), 32'(mbusy[sr1]));
    check("m_b2_nob",    32'(sr2_busy_n), 32'(mbusy[sr2]));
    check("m_we",        32'(we_b),       32'(we));
    check("m_we_nob",    32'(we_n),       32'(we));
    check("m_busyv",     32'(busyv_b),    32'(mbusy));
    check("m_busyv_nob", 32'(busyv_n),    32'(mbusy));
  endtask

  // Advance the model across one rising edge using the held inputs
  task automatic tick();
    logic [15:0] nregs [8];
    logic [7:0]  nbusy;
    logic        stall;
    stall = iv && mbusy[idr] && !(ld && (dr == idr));
    nregs = mregs;
    nbusy = mbusy;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) nregs[i] = 16'h0;
      nbusy = 8'h00;
    end else begin
      if (ld) begin
        nregs[dr] = din;
        nbusy[dr] = 1'b0;
      end
      if (iv && !stall) nbusy[idr] = 1'b1;
    end
    @(posedge clk);
    mregs = nregs;
    mbusy = nbusy;
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; dr = '0; din = '0; sr1 = '0; sr2 = '0; iv = 1'b0; idr = '0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mbusy = 8'h00;

    // Reset with a pending write that must be discarded
    drive(0, 1, 3, 16'hBEEF, 3, 3, 0, 0); tick();
    drive(0, 1, 3, 16'hBEEF, 3, 3, 0, 0); tick();
    drive(1, 0, 0, 0, 3, 3, 0, 0);
    model_check();
    check("rst_sr1", 32'(sr1_out_b), 32'h0000);
    check("rst_busy", 32'(busyv_b), 32'h00);
    check("rst_stall", 32'(stall_b), 32'h0);
    tick();

    // Write every register and verify the one-hot enable
    for (int r = 0; r < 8; r++) begin
      drive(1, 1, r, 16'h1000 + r, 0, 7, 0, 0);
      model_check();
      check("wr_we", 32'(we_b), 32'(8'd1 << r));
      tick();
    end
    for (int r = 0; r < 8; r++) begin
      drive(1, 0, 0, 0, r, 7 - r, 0, 0);
      model_check();
      check("rd_sr1", 32'(sr1_out_b), 32'(16'h1000 + r));
      check("rd_sr2", 32'(sr2_out_n), 32'(16'h1007 - r));
      tick();
    end

    // Same-cycle forwarding versus stored-value read
    drive(1, 1, 5, 16'h0001, 0, 0, 0, 0); tick();
    drive(1, 1, 5, 16'hA5A5, 5, 5, 0, 0);
    model_check();
    check("byp_now", 32'(sr1_out_b), 32'hA5A5);
    check("nob_now", 32'(sr1_out_n), 32'h0001);
    tick();
    drive(1, 0, 0, 0, 5, 0, 0, 0);
    check("nob_next", 32'(sr1_out_n), 32'hA5A5);
    tick();

    // Scoreboard set, WAW stall, and clear by writeback
    drive(1, 0, 0, 0, 0, 0, 1, 2); model_check(); tick();
    drive(1, 0, 0, 0, 0, 2, 0, 0);
    model_check();
    check("sb_busy", 32'(busyv_b), 32'h04);
    check("sb_sr2busy", 32'(sr2_busy_b), 32'h1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 2);
    model_check();
    check("sb_stall", 32'(stall_b), 32'h1);
    tick();
    drive(1, 1, 2, 16'h2222, 0, 2, 0, 0);
    model_check();
    check("sb_unch", 32'(busyv_b), 32'h04);
    check("sb_sr2_fwd_free", 32'(sr2_busy_b), 32'h0);
    check("sb_sr2_nob_busy", 32'(sr2_busy_n), 32'h1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("sb_clear", 32'(busyv_b), 32'h00);
    tick();

    // Writeback and reissue to the same register in one cycle
    drive(1, 0, 0, 0, 0, 0, 1, 4); tick();
    drive(1, 1, 4, 16'h4444, 0, 0, 1, 4);
    model_check();
    check("sim_stall", 32'(stall_b), 32'h0);
    tick();
    drive(1, 0, 0, 0, 4, 0, 0, 0);
    model_check();
    check("sim_reg4", 32'(sr1_out_b), 32'h4444);
    check("sim_busy", 32'(busyv_b), 32'h10);
    tick();
    drive(1, 1, 4, 16'h4444, 0, 0, 0, 0); tick();

    // Reset during activity discards the coincident write and issue
    drive(1, 0, 0, 0, 0, 0, 1, 2); tick();
    drive(1, 0, 0, 0, 0, 0, 1, 3); tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    check("mid_busy", 32'(busyv_b), 32'h0C);
    check("mid_reg1", 32'(sr1_out_b), 32'h1001);
    tick();
    drive(0, 1, 1, 16'hFFFF, 1, 2, 1, 5); tick();
    drive(1, 0, 0, 0, 1, 2, 0, 0);
    model_check();
    check("mid_r1", 32'(sr1_out_b), 32'h0000);
    check("mid_r2", 32'(sr2_out_n), 32'h0000);
    check("mid_busy0", 32'(busyv_n), 32'h00);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 29) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      model_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_sb.md
Name: lc3_regfile_sb

Overview:
Parametrised LC-3 register file. The DR-to-one-hot write-enable decode is folded inside, so no separate decoder is instantiated. Adds two combinational read ports with optional write-through bypass and a per-register busy scoreboard for multi-cycle/pipelined datapath variants. Sits between the DR/SR1/SR2 mux outputs and the ALU/bus, replacing the discrete decoder-plus-8-register arrangement.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 8, number of registers (power of two, >= 2)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only
ADDR_W (localparam), $clog2(NUM_REGS), register address width

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset_n  in  1  synchronous active-low reset
LD_REG  in  1  writeback strobe
DR  in  ADDR_W  writeback destination register
D_in  in  DATA_W  writeback data
SR1  in  ADDR_W  read port 1 address
SR2  in  ADDR_W  read port 2 address
SR1_OUT  out  DATA_W  read port 1 data
SR2_OUT  out  DATA_W  read port 2 data
ISSUE_VALID  in  1  instruction issue request that will later write ISSUE_DR
ISSUE_DR  in  ADDR_W  destination of the issuing instruction
ISSUE_STALL  out  1  issue refused this cycle
SR1_BUSY  out  1  SR1 has a pending, un-bypassed write
SR2_BUSY  out  1  SR2 has a pending, un-bypassed write
WE_VEC  out  NUM_REGS  decoded one-hot write enable (observability)
BUSY_VEC  out  NUM_REGS  scoreboard state

Behaviour:
- Clock and reset: single clock Clk; reset is synchronous and active-low (Reset_n sampled on rising Clk edge).
- Reset priority: when Reset_n=0 at an edge, all registers go to 0 and BUSY_VEC goes to 0. Writes and issues that cycle are discarded. This applies mid-operation too.
- Write-enable decode: WE_VEC = LD_REG ? (1 << DR) : 0. It is purely combinational and exactly one-hot or all-zero, never multi-hot.
- Write: at the rising edge with Reset_n=1 and LD_REG=1, reg[DR] <= D_in. Write latency is 1 cycle.
- Read: SRx_OUT is combinational from reg[SRx].
  - BYPASS=1 and LD_REG=1 and DR==SRx: SRx_OUT = D_in (same-cycle forward).
  - SR1==SR2 is legal; both ports return identical data.
- Scoreboard update per edge (Reset_n=1):
  - LD_REG=1 clears busy[DR].
  - Accepted issue (ISSUE_VALID=1 and ISSUE_STALL=0) sets busy[ISSUE_DR].
  - Same register targeted by both in one cycle: set wins, so busy stays 1 (new producer outstanding).
  - Different registers: both updates apply.
- ISSUE_STALL = ISSUE_VALID && busy[ISSUE_DR] && !(LD_REG && DR==ISSUE_DR). This blocks WAW hazards, but an issue is accepted in the same cycle its destination's writeback arrives.
- SRx_BUSY = busy[SRx] && !(BYPASS && LD_REG && DR==SRx). With BYPASS=0, busy is reported until the cycle after writeback.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- All outputs are combinational from state plus current inputs; there are no output registers.
- Reset values: SR1_OUT and SR2_OUT = 0 (for registers read), BUSY_VEC=0, SRx_BUSY=0, ISSUE_STALL=0 when ISSUE_VALID=0, WE_VEC=0 when LD_REG=0.

Test Plan:
1. Reset_n=0 for 2 cycles with LD_REG=1, DR=3, D_in=16'hBEEF, then release; read SR1=3 -> SR1_OUT=16'h0000, BUSY_VEC=8'h00.
2. Write loop: for each r in 0..7, LD_REG=1, DR=r, D_in=16'h1000+r -> WE_VEC=(1<<r) that cycle; afterwards SR1=r, SR2=7-r return 16'h1000+r and 16'h1007-r.
3. Bypass: BYPASS=1, reg5=16'h0001; in the same cycle LD_REG=1, DR=5, D_in=16'hA5A5, SR1=5 -> SR1_OUT=16'hA5A5 immediately. With BYPASS=0 -> SR1_OUT=16'h0001 that cycle and 16'hA5A5 the next.
4. Scoreboard:
   - ISSUE_VALID=1, ISSUE_DR=2 -> next cycle BUSY_VEC=8'h04, and SR2=2 gives SR2_BUSY=1.
   - Second issue to R2 -> ISSUE_STALL=1 and BUSY_VEC unchanged.
   - LD_REG=1, DR=2 -> BUSY_VEC=8'h00 the next cycle.
5. Simultaneous events: busy[4]=1; in one cycle LD_REG=1, DR=4 and ISSUE_VALID=1, ISSUE_DR=4 -> ISSUE_STALL=0, reg4 updated, BUSY_VEC[4]=1 afterwards.
6. Reset mid-operation: BUSY_VEC=8'h0C and regs nonzero; Reset_n=0 for one edge with LD_REG=1 and ISSUE_VALID=1 -> all regs 0, BUSY_VEC=8'h00, and no write or issue takes effect.
